// File: rtl/pe_accum_unit.sv
// pe_accum_unit
//
// Two-lane partial-sum accumulator that sits behind a PE adder tree.
// Each accepted beat either restarts or extends a saturating accumulation.
// The beat marked last requantizes both lanes to int8 into a one-deep
// output register. Requantization is round-half-up, then arithmetic shift,
// then saturation to int8, then an optional ReLU.
//
// Build option:
//   PE_ACC_RELU_EN  defined   -> relu_en (sampled on the last beat) clamps
//                                negative int8 results to 0
//                   undefined -> no ReLU hardware; relu_en is ignored
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   pe_ofm0, pe_ofm1      21-bit signed partial sums for lane 0 / lane 1
//   in_valid, in_ready    input beat handshake
//   in_first, in_last     beat starts / ends an accumulation
//   shift, relu_en        requantization controls, sampled on the last beat
//   out_data              {lane1 int8, lane0 int8}
//   out_valid, out_ready  output handshake
//   out_ovf               an accumulator saturated during this result
//   out_beats             beats folded into this result (saturating count)

module pe_accum_unit #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [20:0]      pe_ofm0,
    input  logic signed [20:0]      pe_ofm1,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    output logic [15:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_ovf,
    output logic [CNT_W-1:0]        out_beats
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   ONE_W   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0]   Q_MAX   = {{(ACC_W-6){1'b0}}, 7'h7F};
    localparam logic signed [ACC_W:0]   Q_MIN   = {{(ACC_W-6){1'b1}}, 7'h00};

    // Signed add with one guard bit; a disagreement between the guard bit and
    // the top result bit means the true sum left the accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input  logic signed [ACC_W-1:0] a,
        input  logic signed [ACC_W-1:0] b,
        output logic                    sat
    );
        logic signed [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        sat = (sum[ACC_W] != sum[ACC_W-1]);
        if (!sat)
            sat_add = sum[ACC_W-1:0];
        else if (sum[ACC_W])
            sat_add = ACC_MIN;
        else
            sat_add = ACC_MAX;
    endfunction

    // Round, shift and saturate to int8. The guard bit keeps value+bias from
    // wrapping as long as the bias is no larger than 2^(ACC_W-1). Shifts wider
    // than the accumulator always round to zero, so they are short-cut.
    function automatic logic [7:0] requant(
        input logic signed [ACC_W-1:0] v,
        input logic [4:0]              sh
    );
        logic signed [ACC_W:0] wide;
        logic signed [ACC_W:0] bias;
        logic signed [ACC_W:0] shifted;
        wide = {v[ACC_W-1], v};
        bias = '0;
        if (sh != 5'd0)
            bias = ONE_W << (sh - 5'd1);
        shifted = (wide + bias) >>> sh;
        if (int'(sh) > ACC_W)
            requant = 8'h00;
        else if (shifted > Q_MAX)
            requant = 8'h7F;
        else if (shifted < Q_MIN)
            requant = 8'h80;
        else
            requant = shifted[7:0];
    endfunction

    logic signed [ACC_W-1:0] acc0, acc1;
    logic signed [ACC_W-1:0] ext0, ext1;
    logic signed [ACC_W-1:0] acc0_next, acc1_next;
    logic                    sat0, sat1;
    logic                    ovf, ovf_next;
    logic [CNT_W-1:0]        beat_cnt, cnt_next;
    logic [7:0]              q0, q1;
    logic [7:0]              r0, r1;
    logic                    accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign ext0     = {{(ACC_W-21){pe_ofm0[20]}}, pe_ofm0};
    assign ext1     = {{(ACC_W-21){pe_ofm1[20]}}, pe_ofm1};

    // Post-beat accumulator values, sticky overflow and beat count as they
    // would stand after accepting the current beat; a first beat restarts all.
    always_comb begin
        sat0 = 1'b0;
        sat1 = 1'b0;
        if (in_first) begin
            acc0_next = ext0;
            acc1_next = ext1;
        end else begin
            acc0_next = sat_add(acc0, ext0, sat0);
            acc1_next = sat_add(acc1, ext1, sat1);
        end
        ovf_next = (in_first ? 1'b0 : ovf) | sat0 | sat1;
        if (in_first)
            cnt_next = CNT_W'(1);
        else if (&beat_cnt)
            cnt_next = beat_cnt;
        else
            cnt_next = beat_cnt + CNT_W'(1);
    end

    // Per-lane requantization of the post-beat accumulators.
    always_comb begin
        q0 = requant(acc0_next, shift);
        q1 = requant(acc1_next, shift);
    end

`ifdef PE_ACC_RELU_EN
    // ReLU applies to the int8 result; the sign bit marks a negative value.
    always_comb begin
        r0 = (relu_en && q0[7]) ? 8'h00 : q0;
        r1 = (relu_en && q1[7]) ? 8'h00 : q1;
    end
`else
    logic unused_relu_en;
    assign unused_relu_en = relu_en;
    assign r0 = q0;
    assign r1 = q1;
`endif

    // Accumulation state: updated only on accepted beats, and cleared after
    // a last beat so a following beat without first continues from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc0     <= '0;
            acc1     <= '0;
            ovf      <= 1'b0;
            beat_cnt <= '0;
        end else if (accept) begin
            if (in_last) begin
                acc0     <= '0;
                acc1     <= '0;
                ovf      <= 1'b0;
                beat_cnt <= '0;
            end else begin
                acc0     <= acc0_next;
                acc1     <= acc1_next;
                ovf      <= ovf_next;
                beat_cnt <= cnt_next;
            end
        end
    end

    // Output register: loads on an accepted last beat, holds while stalled,
    // and stays valid without a bubble when a drain and a load coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_beats <= '0;
        end else if (accept && in_last) begin
            out_valid <= 1'b1;
            out_data  <= {r1, r0};
            out_ovf   <= ovf_next;
            out_beats <= cnt_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
